// File: rtl/mod_button_gesture_if.sv
// Signal bundle between the button debouncer / UI logic and mod_button_gesture.
// slave is the gesture classifier's view; master is the driver/observer view.
`timescale 1ns/1ps
interface mod_button_gesture_if;
    logic press_i;
    logic chg_i;
    logic click_o;
    logic dbl_o;
    logic long_o;
    logic rpt_o;
    logic held_o;
    logic busy_o;

    modport master (
        output press_i, chg_i,
        input  click_o, dbl_o, long_o, rpt_o, held_o, busy_o
    );

    modport slave (
        input  press_i, chg_i,
        output click_o, dbl_o, long_o, rpt_o, held_o, busy_o
    );
endinterface

// File: rtl/mod_button_gesture.sv
// Classifies debounced button press/release pulses into click, double-click,
// long-press and auto-repeat events using one shared cycle counter.
`timescale 1ns/1ps
module mod_button_gesture #(
    parameter int unsigned LONG_CYC    = 1_000_000,
    parameter int unsigned DBL_GAP_CYC = 250_000,
    parameter int unsigned REPEAT_CYC  = 100_000,
    parameter bit          DBL_EN      = 1'b1,
    parameter int unsigned CNT_W       = 24
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    mod_button_gesture_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS1,
        ST_REL1,
        ST_LONG,
        ST_WAIT_REL
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'((REPEAT_CYC == 0) ? 0 : REPEAT_CYC - 1);
    localparam bit               RPT_EN    = (REPEAT_CYC != 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             click_q, click_d;
    logic             dbl_q, dbl_d;
    logic             long_q, long_d;
    logic             rpt_q, rpt_d;
    logic             held_q, held_d;
    logic             busy_q, busy_d;

    logic press;
    logic rel;

    assign press = bus.press_i;
    assign rel   = bus.chg_i & ~bus.press_i;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        click_d = 1'b0;
        dbl_d   = 1'b0;
        long_d  = 1'b0;
        rpt_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (press) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                // Release on the threshold cycle is still a short press.
                if (rel) begin
                    cnt_d = '0;
                    if (DBL_EN) begin
                        state_d = ST_REL1;
                    end else begin
                        state_d = ST_IDLE;
                        click_d = 1'b1;
                    end
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end
            end
            ST_REL1: begin
                if (press) begin
                    state_d = ST_WAIT_REL;
                    cnt_d   = '0;
                    dbl_d   = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    click_d = 1'b1;
                end
            end
            ST_LONG: begin
                // With repeat disabled the counter parks at zero instead of running free.
                if (!RPT_EN) cnt_d = '0;
                if (rel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (RPT_EN && cnt_q == RPT_LAST) begin
                    cnt_d = '0;
                    rpt_d = 1'b1;
                end
            end
            ST_WAIT_REL: begin
                cnt_d = '0;
                if (rel) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d == ST_PRESS1) || (state_d == ST_LONG) || (state_d == ST_WAIT_REL);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            click_q <= 1'b0;
            dbl_q   <= 1'b0;
            long_q  <= 1'b0;
            rpt_q   <= 1'b0;
            held_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            click_q <= click_d;
            dbl_q   <= dbl_d;
            long_q  <= long_d;
            rpt_q   <= rpt_d;
            held_q  <= held_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.click_o = click_q;
    assign bus.dbl_o   = dbl_q;
    assign bus.long_o  = long_q;
    assign bus.rpt_o   = rpt_q;
    assign bus.held_o  = held_q;
    assign bus.busy_o  = busy_q;

endmodule

// File: tb/tb_mod_button_gesture.sv
// Scoreboard bench for mod_button_gesture: three instances (default, DBL_EN=0,
// REPEAT_CYC=0) share stimulus; expected events are queued as stimulus is planned.
`timescale 1ns/1ps
module tb_mod_button_gesture;

    localparam int LONG = 20;
    localparam int GAP  = 10;
    localparam int RPT  = 8;
    localparam int MAXC = 100;

    typedef enum logic [1:0] {EV_CLICK, EV_DBL, EV_LONG, EV_RPT} ev_e;
    typedef struct {
        ev_e kind;
        int  cyc;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mod_button_gesture_if if_a ();
    mod_button_gesture_if if_b ();
    mod_button_gesture_if if_c ();

    mod_button_gesture #(.LONG_CYC(LONG), .DBL_GAP_CYC(GAP), .REPEAT_CYC(RPT),
                         .DBL_EN(1'b1), .CNT_W(8))
        dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(if_a.slave));
    mod_button_gesture #(.LONG_CYC(LONG), .DBL_GAP_CYC(GAP), .REPEAT_CYC(RPT),
                         .DBL_EN(1'b0), .CNT_W(8))
        dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(if_b.slave));
    mod_button_gesture #(.LONG_CYC(LONG), .DBL_GAP_CYC(GAP), .REPEAT_CYC(0),
                         .DBL_EN(1'b1), .CNT_W(8))
        dut_c (.clk_i(clk), .rst_ni(rst_n), .bus(if_c.slave));

    int  vectors     = 0;
    int  miscompares = 0;

    ev_t exp_a[$];
    ev_t exp_b[$];
    ev_t exp_c[$];

    bit  press_at [MAXC];
    bit  rel_at   [MAXC];
    bit  busy_log [MAXC];
    bit  held_log [MAXC];
    int  rst_from;
    int  rst_to;
    bit  [2:0] chk;

    task automatic set_in(input bit p, input bit r);
        if_a.press_i = p; if_a.chg_i = p | r;
        if_b.press_i = p; if_b.chg_i = p | r;
        if_c.press_i = p; if_c.chg_i = p | r;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            press_at[i] = 1'b0;
            rel_at[i]   = 1'b0;
            busy_log[i] = 1'b0;
            held_log[i] = 1'b0;
        end
        rst_from = -1;
        rst_to   = -1;
        chk      = 3'b000;
    endtask

    function automatic ev_t mk(input ev_e k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        return e;
    endfunction

    // Pops the expected event for every pulse a DUT raises and compares kind and cycle.
    task automatic sb_compare(input int d, input logic [3:0] pul, input int n);
        ev_t e;
        bit  have;
        vectors++;
        if ($countones(pul) > 1) begin
            miscompares++;
            $display("FAIL one_hot dut%0d cyc %0d: pulses=%b, required at most one high", d, n, pul);
        end
        for (int k = 0; k < 4; k++) begin
            if (pul[k]) begin
                have = 1'b0;
                e    = mk(EV_CLICK, -1);
                case (d)
                    0: if (exp_a.size() > 0) begin e = exp_a.pop_front(); have = 1'b1; end
                    1: if (exp_b.size() > 0) begin e = exp_b.pop_front(); have = 1'b1; end
                    default: if (exp_c.size() > 0) begin e = exp_c.pop_front(); have = 1'b1; end
                endcase
                vectors++;
                if (!have) begin
                    miscompares++;
                    $display("FAIL unexpected_event dut%0d: kind %0d at cyc %0d, required no event", d, k, n);
                end else if (e.kind !== ev_e'(k) || e.cyc != n) begin
                    miscompares++;
                    $display("FAIL event dut%0d: got kind %0d at cyc %0d, required kind %0d at cyc %0d",
                             d, k, n, e.kind, e.cyc);
                end
            end
        end
    endtask

    task automatic sb_drain(input int d);
        int sz;
        ev_t e;
        sz = (d == 0) ? exp_a.size() : (d == 1) ? exp_b.size() : exp_c.size();
        vectors++;
        if (sz != 0) begin
            miscompares++;
            e = (d == 0) ? exp_a[0] : (d == 1) ? exp_b[0] : exp_c[0];
            $display("FAIL missing_event dut%0d: %0d pending, first kind %0d at cyc %0d, required 0 pending",
                     d, sz, e.kind, e.cyc);
        end
        exp_a.delete(); exp_b.delete(); exp_c.delete();
    endtask

    // Entered just after a rising edge; cycle n's inputs are sampled at the edge ending cycle n.
    task automatic run_window(input int ncyc);
        for (int n = 0; n < ncyc; n++) begin
            rst_n = !(n >= rst_from && n <= rst_to);
            set_in(press_at[n], rel_at[n]);
            @(negedge clk);
            busy_log[n] = if_a.busy_o;
            held_log[n] = if_a.held_o;
            if (chk[0]) sb_compare(0, {if_a.rpt_o, if_a.long_o, if_a.dbl_o, if_a.click_o}, n);
            if (chk[1]) sb_compare(1, {if_b.rpt_o, if_b.long_o, if_b.dbl_o, if_b.click_o}, n);
            if (chk[2]) sb_compare(2, {if_c.rpt_o, if_c.long_o, if_c.dbl_o, if_c.click_o}, n);
            @(posedge clk);
            #1;
        end
        set_in(1'b0, 1'b0);
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) if (chk[d]) sb_drain(d);
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        set_in(1'b0, 1'b0);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            obs = {if_a.click_o, if_a.dbl_o, if_a.long_o, if_a.rpt_o, if_a.held_o, if_a.busy_o};
            vectors++;
            if (obs !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_outputs_a: got %b, required 000000", obs);
            end
            obs = {if_b.click_o, if_b.busy_o, if_b.held_o, if_c.click_o, if_c.busy_o, if_c.held_o};
            vectors++;
            if (obs !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_outputs_bc: got %b, required 000000", obs);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        obs = {if_a.click_o, if_a.dbl_o, if_a.long_o, if_a.rpt_o, if_a.held_o, if_a.busy_o};
        vectors++;
        if (obs !== 6'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b, required 000000", obs);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_click();
        clear_stim();
        chk = 3'b001;
        press_at[0] = 1'b1;
        rel_at[5]   = 1'b1;
        exp_a.push_back(mk(EV_CLICK, 5 + GAP + 1));
        run_window(20);
        vectors++;
        if ({busy_log[0], busy_log[1], busy_log[15], busy_log[17]} !== 4'b0110) begin
            miscompares++;
            $display("FAIL click_busy: got b0,b1,b15,b17=%b, required 0110",
                     {busy_log[0], busy_log[1], busy_log[15], busy_log[17]});
        end
        vectors++;
        if ({held_log[3], held_log[8]} !== 2'b10) begin
            miscompares++;
            $display("FAIL click_held: got h3,h8=%b, required 10", {held_log[3], held_log[8]});
        end
    endtask

    task automatic test_double();
        clear_stim();
        chk = 3'b001;
        press_at[0] = 1'b1;
        rel_at[5]   = 1'b1;
        press_at[9] = 1'b1;
        rel_at[12]  = 1'b1;
        exp_a.push_back(mk(EV_DBL, 9 + 1));
        run_window(30);
        vectors++;
        if ({held_log[12], held_log[13], busy_log[13]} !== 3'b100) begin
            miscompares++;
            $display("FAIL dbl_levels: got h12,h13,b13=%b, required 100",
                     {held_log[12], held_log[13], busy_log[13]});
        end
    endtask

    task automatic test_long_repeat();
        int c;
        clear_stim();
        chk = 3'b001;
        press_at[0] = 1'b1;
        rel_at[50]  = 1'b1;
        exp_a.push_back(mk(EV_LONG, LONG + 1));
        c = LONG + RPT + 1;
        while (c <= 50) begin
            exp_a.push_back(mk(EV_RPT, c));
            c += RPT;
        end
        run_window(60);
        vectors++;
        if ({held_log[30], busy_log[50], busy_log[51]} !== 3'b110) begin
            miscompares++;
            $display("FAIL long_levels: got h30,b50,b51=%b, required 110",
                     {held_log[30], busy_log[50], busy_log[51]});
        end
    endtask

    task automatic test_boundaries();
        clear_stim();
        chk = 3'b001;
        press_at[0] = 1'b1;
        rel_at[LONG] = 1'b1;
        exp_a.push_back(mk(EV_CLICK, LONG + GAP + 1));
        run_window(35);

        clear_stim();
        chk = 3'b001;
        press_at[0]   = 1'b1;
        rel_at[5]     = 1'b1;
        press_at[15]  = 1'b1;
        rel_at[18]    = 1'b1;
        exp_a.push_back(mk(EV_DBL, 15 + 1));
        run_window(25);
        vectors++;
        if (busy_log[20] !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_edge_idle: got busy=%b at 20, required 0", busy_log[20]);
        end
    endtask

    task automatic test_reset_mid_hold();
        int active;
        clear_stim();
        chk = 3'b001;
        press_at[0] = 1'b1;
        rel_at[18]  = 1'b1;
        rst_from    = 10;
        rst_to      = 12;
        run_window(40);
        active = 0;
        for (int i = 10; i < 40; i++) active += int'(busy_log[i] | held_log[i]);
        vectors++;
        if (busy_log[5] !== 1'b1 || active != 0) begin
            miscompares++;
            $display("FAIL reset_mid_hold: got busy5=%b active_cycles_after_10=%0d, required 1 and 0",
                     busy_log[5], active);
        end
    endtask

    task automatic test_back_to_back();
        clear_stim();
        chk = 3'b001;
        press_at[0]  = 1'b1;
        press_at[1]  = 1'b1;
        rel_at[2]    = 1'b1;
        press_at[13] = 1'b1;
        rel_at[16]   = 1'b1;
        rel_at[29]   = 1'b1;
        exp_a.push_back(mk(EV_CLICK, 2 + GAP + 1));
        exp_a.push_back(mk(EV_CLICK, 16 + GAP + 1));
        run_window(35);
        vectors++;
        if ({busy_log[14], busy_log[30]} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_busy: got b14,b30=%b, required 10", {busy_log[14], busy_log[30]});
        end
    endtask

    task automatic test_no_dbl();
        clear_stim();
        chk = 3'b010;
        press_at[0] = 1'b1;
        rel_at[5]   = 1'b1;
        press_at[9] = 1'b1;
        rel_at[12]  = 1'b1;
        exp_b.push_back(mk(EV_CLICK, 5 + 1));
        exp_b.push_back(mk(EV_CLICK, 12 + 1));
        run_window(30);
    endtask

    task automatic test_no_repeat();
        clear_stim();
        chk = 3'b100;
        press_at[0] = 1'b1;
        rel_at[40]  = 1'b1;
        exp_c.push_back(mk(EV_LONG, LONG + 1));
        run_window(50);
    endtask

    initial begin
        set_in(1'b0, 1'b0);
        test_reset();
        test_click();
        test_double();
        test_long_repeat();
        test_boundaries();
        test_reset_mid_hold();
        test_back_to_back();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_no_dbl();
        test_no_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
